mdu_sched: RTL and testbench
============================

Name: mdu_sched

Overview:
- Multiply/divide scheduler for the 5-stage pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage.
- Models the multi-cycle latency with a busy counter and owns the HI/LO architectural registers.
- Generates the D-stage stall for any multiply/divide-class instruction that would observe HI/LO or start the unit while it is occupied. The forwarding controller is unaffected; this block only adds a stall source.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1).
- DIV_CYCLES, 10, busy cycles for div/divu (≥1).

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- E_md_op  in  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- E_rs  in  WIDTH  forwarded rs value in E.
- E_rt  in  WIDTH  forwarded rt value in E.
- D_is_md  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  out  1  unit is occupied by an in-flight mult/div.
- stall_md  out  1  combinational stall request to D/F (ORed into the global stall by the top level).
- HI  out  WIDTH  architectural HI register.
- LO  out  WIDTH  architectural LO register.

Behaviour:
- Reset (reset_n=0, asynchronous): busy=0, counter=0, HI=0, LO=0, pending result discarded. An operation in flight at reset is lost and never commits.
- Start: at the rising edge where busy=0 and E_md_op∈{1..4}:
  - compute the result into pending_hi/pending_lo;
  - load the counter with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4);
  - set busy=1.
- Busy phase: the counter decrements each edge while busy=1. At the edge where the counter equals 1, HI/LO take the pending values, the counter becomes 0 and busy falls.
  - Result: busy is high for exactly N cycles; new HI/LO are visible in the first cycle busy=0.
- Arithmetic:
  - mult: signed 32x32 → 64, HI=upper, LO=lower. multu: unsigned.
  - div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend (rs). divu: unsigned.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divisor 0 (div/divu): busy sequence runs normally, but HI/LO are left unchanged at commit.
- mthi/mtlo (ops 5,6) with busy=0: HI (or LO) ← E_rs at that edge, no busy phase.
- Any E_md_op while busy=1 is a protocol violation and is ignored (no start, no HI/LO write). stall_md makes this unreachable in a correct pipeline.
- stall_md = D_is_md & (busy | E_md_op∈{1..4}). Combinational, with no register stage:
  - covers the start cycle before busy rises;
  - mfhi/mflo in D is stalled until HI/LO hold the committed value.
- Non-MD instructions are never stalled by this block. Pipeline flow continues while busy.
- Back-to-back: a new start is accepted in the first cycle busy=0 (the commit edge and the next start edge are distinct). No start/commit can occur on the same edge.
- mfhi/mflo read HI/LO directly in D or E. HI/LO are stable whenever stall_md=0 for an MD instruction in D.

Test Plan:
- Reset then idle: HI=LO=0, busy=0, stall_md=0. Assert reset_n=0 during busy → busy=0 immediately, HI/LO stay 0 after release.
- mult rs=0xFFFFFFFE(-2), rt=3:
  - busy high exactly 5 cycles;
  - HI=0xFFFFFFFF, LO=0xFFFFFFFA visible in the cycle busy falls.
  - Same operands with multu → HI=0x00000002, LO=0xFFFFFFFA.
- div rs=-7 (0xFFFFFFF9), rt=2 → busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 → HI/LO unchanged after 10 busy cycles.
- mflo in D while mult in E:
  - stall_md=1 in the start cycle and all 5 busy cycles, then 0;
  - the mflo reads the new LO.
  - An add in D in the same window → stall_md=0.
- mthi rs=0x12345678 with busy=0 → HI=0x12345678 next cycle, busy stays 0. Then issue mult and mtlo back-to-back in D → mtlo stalled until busy falls, then LO=rs of mtlo.
- div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. Immediately start divu in the first idle cycle → accepted, busy re-rises the next cycle.

Source files
------------

// File: rtl/mdu_sched.sv
// rtl/mdu_sched.sv - multiply/divide scheduler: busy counter, HI/LO registers, D-stage stall
module mdu_sched #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       E_md_op,
  input  logic [WIDTH-1:0] E_rs,
  input  logic [WIDTH-1:0] E_rt,
  input  logic             D_is_md,
  output logic             busy,
  output logic             stall_md,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             is_mul, is_div, is_signed, start;
  logic [2*WIDTH-1:0] mul_a, mul_b, mul_p;
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] div_a_mag, div_b_mag, div_b_safe;
  logic [WIDTH-1:0] quo_mag, rem_mag, quo, rem;

  always_comb begin
    is_mul    = (E_md_op == OP_MULT) || (E_md_op == OP_MULTU);
    is_div    = (E_md_op == OP_DIV)  || (E_md_op == OP_DIVU);
    is_signed = (E_md_op == OP_MULT) || (E_md_op == OP_DIV);
    start     = !busy_q && (is_mul || is_div);
  end

  // One 2W-bit multiplier serves both flavours: sign- or zero-extend, keep the low 2W bits.
  always_comb begin
    mul_a = is_signed ? {{WIDTH{E_rs[WIDTH-1]}}, E_rs} : {{WIDTH{1'b0}}, E_rs};
    mul_b = is_signed ? {{WIDTH{E_rt[WIDTH-1]}}, E_rt} : {{WIDTH{1'b0}}, E_rt};
    mul_p = mul_a * mul_b;
  end

  // Magnitude division keeps MIN/-1 well defined: quotient wraps to MIN, remainder 0.
  always_comb begin
    neg_a      = is_signed & E_rs[WIDTH-1];
    neg_b      = is_signed & E_rt[WIDTH-1];
    div_a_mag  = neg_a ? -E_rs : E_rs;
    div_b_mag  = neg_b ? -E_rt : E_rt;
    div_b_safe = (div_b_mag == '0) ? WIDTH'(1) : div_b_mag;
    quo_mag    = div_a_mag / div_b_safe;
    rem_mag    = div_a_mag % div_b_safe;
    quo        = (neg_a ^ neg_b) ? -quo_mag : quo_mag;
    rem        = neg_a ? -rem_mag : rem_mag;
  end

  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (busy_q) begin
      // Any op arriving while occupied is ignored; only the countdown advances.
      if (cnt_q == CNT_ONE) begin
        busy_d = 1'b0;
        cnt_d  = '0;
        if (pend_wr_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end else if (start) begin
      busy_d    = 1'b1;
      cnt_d     = is_mul ? MULT_LOAD : DIV_LOAD;
      pend_wr_d = is_mul || (E_rt != '0);
      pend_hi_d = is_mul ? mul_p[2*WIDTH-1:WIDTH] : rem;
      pend_lo_d = is_mul ? mul_p[WIDTH-1:0]       : quo;
    end else if (E_md_op == OP_MTHI) begin
      hi_d = E_rs;
    end else if (E_md_op == OP_MTLO) begin
      lo_d = E_rs;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign HI       = hi_q;
  assign LO       = lo_q;
  assign stall_md = D_is_md & (busy_q | is_mul | is_div);

endmodule

// File: tb/tb_mdu_sched.sv
// tb/tb_mdu_sched.sv - scoreboard bench for mdu_sched
module tb_mdu_sched;

  localparam int S_STALL = 0;
  localparam int S_BUSY  = 1;
  localparam int S_HI    = 2;
  localparam int S_LO    = 3;

  logic        clk;
  logic        reset_n;
  logic [2:0]  E_md_op;
  logic [31:0] E_rs;
  logic [31:0] E_rt;
  logic        D_is_md;
  logic        busy;
  logic        stall_md;
  logic [31:0] HI;
  logic [31:0] LO;

  mdu_sched #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .E_md_op  (E_md_op),
    .E_rs     (E_rs),
    .E_rt     (E_rt),
    .D_is_md  (D_is_md),
    .busy     (busy),
    .stall_md (stall_md),
    .HI       (HI),
    .LO       (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } cmt_t;

  chk_t chk_q[$];
  cmt_t cmt_q[$];
  int   total;
  int   bad;
  int   run;
  logic prev_busy;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic dmd);
    E_md_op = op;
    E_rs    = rs;
    E_rt    = rt;
    D_is_md = dmd;
  endtask

  task automatic expc(input string name, input int sel, input logic [31:0] v);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = v;
    chk_q.push_back(c);
  endtask

  task automatic push_cmt(input string name, input logic [31:0] hi, input logic [31:0] lo,
                          input int len);
    cmt_t c;
    c.name = name;
    c.hi   = hi;
    c.lo   = lo;
    c.len  = len;
    cmt_q.push_back(c);
  endtask

  initial begin
    reset_n   = 1'b0;
    E_md_op   = 3'd0;
    E_rs      = '0;
    E_rt      = '0;
    D_is_md   = 1'b0;
    total     = 0;
    bad       = 0;
    run       = 0;
    prev_busy = 1'b0;
    fork
      begin : stim
        tick;
        tick;
        expc("rst_busy", S_BUSY, 32'd0);
        expc("rst_hi", S_HI, 32'd0);
        expc("rst_lo", S_LO, 32'd0);
        expc("rst_stall", S_STALL, 32'd0);
        tick;
        reset_n = 1'b1;
        tick;
        expc("idle_busy", S_BUSY, 32'd0);
        expc("idle_stall", S_STALL, 32'd0);
        tick;

        // mult -2*3 with mflo waiting in D
        drive(3'd1, 32'hFFFFFFFE, 32'd3, 1'b1);
        expc("mult_start_stall", S_STALL, 32'd1);
        expc("mult_start_busy", S_BUSY, 32'd0);
        push_cmt("mult", 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        tick;
        drive(3'd0, '0, '0, 1'b1);
        for (int i = 0; i < 5; i++) begin
          expc("mflo_busy_stall", S_STALL, 32'd1);
          expc("mult_busy", S_BUSY, 32'd1);
          tick;
        end
        expc("mflo_release_stall", S_STALL, 32'd0);
        expc("mflo_lo", S_LO, 32'hFFFFFFFA);
        tick;

        // multu with an add in D
        drive(3'd2, 32'hFFFFFFFE, 32'd3, 1'b0);
        expc("add_start_stall", S_STALL, 32'd0);
        push_cmt("multu", 32'h00000002, 32'hFFFFFFFA, 5);
        tick;
        drive(3'd0, '0, '0, 1'b0);
        for (int i = 0; i < 5; i++) begin
          expc("add_busy_stall", S_STALL, 32'd0);
          tick;
        end
        tick;

        // div -7/2, then divu 7/0 keeps HI/LO
        drive(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        push_cmt("div", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        tick;
        drive(3'd0, '0, '0, 1'b0);
        repeat (10) tick;
        drive(3'd4, 32'd7, 32'd0, 1'b0);
        push_cmt("divu_by0", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        tick;
        drive(3'd0, '0, '0, 1'b0);
        repeat (10) tick;

        // mthi, then mult followed by mtlo stalled in D
        drive(3'd5, 32'h12345678, '0, 1'b0);
        tick;
        drive(3'd0, '0, '0, 1'b0);
        expc("mthi_hi", S_HI, 32'h12345678);
        expc("mthi_busy", S_BUSY, 32'd0);
        tick;
        drive(3'd1, 32'd3, 32'd4, 1'b1);
        expc("mtlo_start_stall", S_STALL, 32'd1);
        push_cmt("mult_3x4", 32'd0, 32'd12, 5);
        tick;
        drive(3'd0, '0, '0, 1'b1);
        for (int i = 0; i < 5; i++) begin
          expc("mtlo_busy_stall", S_STALL, 32'd1);
          tick;
        end
        expc("mtlo_release_stall", S_STALL, 32'd0);
        tick;
        drive(3'd6, 32'hCAFEF00D, '0, 1'b0);
        expc("mtlo_e_stall", S_STALL, 32'd0);
        tick;
        drive(3'd0, '0, '0, 1'b0);
        expc("mtlo_lo", S_LO, 32'hCAFEF00D);
        expc("mtlo_busy", S_BUSY, 32'd0);
        tick;

        // MIN / -1, then divu in the first idle cycle
        drive(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        push_cmt("div_ovf", 32'd0, 32'h80000000, 10);
        tick;
        drive(3'd0, '0, '0, 1'b0);
        repeat (10) tick;
        drive(3'd4, 32'd100, 32'd7, 1'b0);
        expc("b2b_idle_busy", S_BUSY, 32'd0);
        expc("b2b_idle_lo", S_LO, 32'h80000000);
        push_cmt("divu_b2b", 32'd2, 32'd14, 10);
        tick;
        drive(3'd0, '0, '0, 1'b0);
        expc("b2b_rise_busy", S_BUSY, 32'd1);
        tick;
        tick;
        drive(3'd6, 32'hDEADBEEF, '0, 1'b0);
        tick;
        drive(3'd1, 32'd5, 32'd5, 1'b0);
        expc("ignored_mtlo_lo", S_LO, 32'h80000000);
        expc("ignored_busy", S_BUSY, 32'd1);
        tick;
        drive(3'd0, '0, '0, 1'b0);
        repeat (6) tick;
        tick;

        // reset in the middle of a mult
        drive(3'd1, 32'd5, 32'd5, 1'b0);
        tick;
        drive(3'd0, '0, '0, 1'b0);
        tick;
        tick;
        reset_n = 1'b0;
        #1;
        expc("arst_busy", S_BUSY, 32'd0);
        expc("arst_hi", S_HI, 32'd0);
        expc("arst_lo", S_LO, 32'd0);
        tick;
        tick;
        reset_n = 1'b1;
        repeat (8) tick;
        expc("post_rst_hi", S_HI, 32'd0);
        expc("post_rst_lo", S_LO, 32'd0);
        expc("post_rst_busy", S_BUSY, 32'd0);
        tick;
        tick;
      end
      begin : mon
        forever begin
          @(negedge clk);
          if (!reset_n) begin
            run = 0;
          end else if (busy) begin
            run++;
          end else if (prev_busy) begin
            if (cmt_q.size() == 0) begin
              cmp("unexpected_commit", 32'd1, 32'd0);
            end else begin
              cmt_t c;
              c = cmt_q.pop_front();
              cmp({c.name, "_hi"}, HI, c.hi);
              cmp({c.name, "_lo"}, LO, c.lo);
              cmp({c.name, "_len"}, run, c.len);
            end
            run = 0;
          end
          prev_busy = busy;
          while (chk_q.size() != 0) begin
            chk_t k;
            k = chk_q.pop_front();
            case (k.sel)
              S_STALL: cmp(k.name, {31'd0, stall_md}, k.exp);
              S_BUSY:  cmp(k.name, {31'd0, busy}, k.exp);
              S_HI:    cmp(k.name, HI, k.exp);
              default: cmp(k.name, LO, k.exp);
            endcase
          end
        end
      end
    join_any
    disable fork;
    cmp("commits_drained", cmt_q.size(), 32'd0);
    cmp("checks_drained", chk_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
